popcount_seq_ctrl: RTL and testbench

- Sequencing controller that computes the population count of a wide WIDTH-bit word by time-multiplexing one shared 8-bit popcount datapath (popcount_int8, A[7:0] -> Y[3:0]).
- Accepts a word over a valid/ready input handshake and feeds one byte per cycle, LSB byte first, into the shared datapath.
- Accumulates the partial counts and presents the total over a valid/ready output handshake.
- Serves as the area-lean front end for wide popcount in PIM synthesis benchmarks.

---
 rtl/popcount_seq_ctrl_if.sv | 25 ++
 rtl/popcount_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_popcount_seq_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/popcount_seq_ctrl_if.sv
// Handshake bundle for popcount_seq_ctrl: word in, count out.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry it.
interface popcount_seq_ctrl_if #(
    parameter int WIDTH = 64
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/popcount_seq_ctrl.sv
// Wide popcount by feeding one byte per cycle into a shared 8-bit counter.
// Latency: result valid N_CHUNK cycles after the input handshake.
// Backpressure: one word in flight; in_ready stays low until the result is taken.
module popcount_int8 (
    input  logic [7:0] a,
    output logic [3:0] y
);
    always_comb begin
        y = 4'd0;
        for (int i = 0; i < 8; i++) begin
            y = y + {3'b000, a[i]};
        end
    end
endmodule

module popcount_seq_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    output logic               busy,
    popcount_seq_ctrl_if.slave bus
);
    localparam int N_CHUNK = WIDTH / 8;
    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

    if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
        $error("popcount_seq_ctrl: WIDTH must be a multiple of 8 and >= 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] acc;
    logic [3:0]       chunk_cnt;
    logic             init_done;
    logic             accept;
    logic             last_chunk;

    popcount_int8 u_pc8 (
        .a (shreg[7:0]),
        .y (chunk_cnt)
    );

    assign accept     = bus.in_valid & bus.in_ready;
    assign last_chunk = (idx == IDX_W'(N_CHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                // init_done holds off acceptance until the first edge after reset release
                bus.in_ready = !abort && init_done;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) state_nxt = DONE;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign bus.out_count = bus.out_valid ? acc : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            idx       <= '0;
            acc       <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (abort) begin
                acc <= '0;
                idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            shreg <= bus.in_data;
                            acc   <= '0;
                            idx   <= '0;
                        end
                    end
                    RUN: begin
                        acc   <= acc + CNT_W'(chunk_cnt);
                        shreg <= shreg >> 8;
                        idx   <= last_chunk ? '0 : idx + IDX_W'(1);
                    end
                    DONE: begin
                        if (bus.out_ready) acc <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Directed bench for popcount_seq_ctrl at WIDTH=64 and WIDTH=8.
module tb_popcount_seq_ctrl;
    logic clk;
    logic rst_n;
    logic abort64, abort8;
    logic busy64, busy8;

    popcount_seq_ctrl_if #(.WIDTH(64)) bus64 ();
    popcount_seq_ctrl_if #(.WIDTH(8))  bus8 ();

    popcount_seq_ctrl #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .abort(abort64), .busy(busy64), .bus(bus64)
    );
    popcount_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .abort(abort8), .busy(busy8), .bus(bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] data;
        int          exp;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic get_in_ready(input bit w8);
        return w8 ? bus8.in_ready : bus64.in_ready;
    endfunction
    function automatic logic get_out_valid(input bit w8);
        return w8 ? bus8.out_valid : bus64.out_valid;
    endfunction
    function automatic logic [63:0] get_count(input bit w8);
        return w8 ? 64'(bus8.out_count) : 64'(bus64.out_count);
    endfunction
    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy64;
    endfunction

    task automatic set_in(input bit w8, input logic v, input logic [63:0] d);
        if (w8) begin
            bus8.in_valid = v;
            bus8.in_data  = d[7:0];
        end else begin
            bus64.in_valid = v;
            bus64.in_data  = d;
        end
    endtask

    task automatic wait_ready(input bit w8, input string nm);
        int t = 0;
        while (!get_in_ready(w8) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!get_in_ready(w8)) check({nm, " ready_timeout"}, 0, 1);
    endtask

    // Full transaction with out_ready high; checks latency, count and return to IDLE.
    task automatic run_word(input bit w8, input logic [63:0] d, input int exp_cnt,
                            input int exp_lat, input string nm);
        int  k = 0;
        if (w8) bus8.out_ready = 1'b1; else bus64.out_ready = 1'b1;
        wait_ready(w8, nm);
        set_in(w8, 1'b1, d);
        @(posedge clk); #1;
        set_in(w8, 1'b0, ~d);
        check({nm, " busy"}, 64'(get_busy(w8)), 1);
        while (!get_out_valid(w8) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check({nm, " latency"}, 64'(k), 64'(exp_lat));
        check({nm, " count"}, get_count(w8), 64'(exp_cnt));
        @(posedge clk); #1;
        check({nm, " idle_after"}, {62'd0, get_out_valid(w8), get_busy(w8)}, 0);
        check({nm, " count_cleared"}, get_count(w8), 0);
    endtask

    initial begin
        bit flag;
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[1] = '{64'h0123_4567_89AB_CDEF, 32};
        vecs[2] = '{64'h0000_0000_0000_0000, 0};
        vecs[3] = '{64'h8000_0000_0000_0001, 2};
        vecs[4] = '{64'h0000_0000_0000_00FF, 8};
        vecs[5] = '{64'hF0F0_F0F0_F0F0_F0F0, 32};
        vecs[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 32};
        vecs[7] = '{64'h0000_0000_0000_0100, 1};
        vecs[8] = '{64'hFFFF_0000_0000_0000, 16};

        rst_n = 1'b0;
        abort64 = 1'b0; abort8 = 1'b0;
        set_in(0, 1'b0, 64'd0); set_in(1, 1'b0, 64'd0);
        bus64.out_ready = 1'b0; bus8.out_ready = 1'b0;

        @(posedge clk); @(posedge clk); #1;
        check("reset outs64", {60'd0, bus64.in_ready, bus64.out_valid, busy64, 1'b0}, 0);
        check("reset count64", get_count(0), 0);
        check("reset outs8", {61'd0, bus8.in_ready, bus8.out_valid, busy8}, 0);
        rst_n = 1'b1;
        #1 check("in_ready before edge", 64'(bus64.in_ready), 0);
        @(posedge clk); #1;
        check("in_ready after edge", 64'(bus64.in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            run_word(0, vecs[i].data, vecs[i].exp, 8, $sformatf("vec%0d", i));
        end

        // Back-to-back offer: second word must wait for the first handshake.
        bus64.out_ready = 1'b1;
        wait_ready(0, "b2b");
        set_in(0, 1'b1, 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        bus64.in_data = 64'h0;
        flag = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus64.in_ready) flag = 1'b1;
            @(posedge clk); #1;
        end
        check("b2b ready_low_run", 64'(flag), 0);
        check("b2b first_valid", 64'(bus64.out_valid), 1);
        check("b2b first_count", get_count(0), 32);
        check("b2b ready_low_done", 64'(bus64.in_ready), 0);
        @(posedge clk); #1;
        check("b2b ready_after_hs", 64'(bus64.in_ready), 1);
        @(posedge clk); #1;
        set_in(0, 1'b0, 64'd0);
        check("b2b second_accepted", 64'(busy64), 1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        check("b2b second_valid", 64'(bus64.out_valid), 1);
        check("b2b second_count", get_count(0), 0);
        @(posedge clk); #1;

        // Result held under backpressure.
        bus64.out_ready = 1'b0;
        wait_ready(0, "hold");
        set_in(0, 1'b1, 64'h8000_0000_0000_0001);
        @(posedge clk); #1;
        set_in(0, 1'b0, 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        check("hold valid", 64'(bus64.out_valid), 1);
        flag = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (!bus64.out_valid || bus64.out_count != 7'd2) flag = 1'b0;
        end
        check("hold stable", 64'(flag), 1);
        bus64.out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold released", {62'd0, bus64.out_valid, busy64}, 0);
        flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus64.out_valid) flag = 1'b1;
        end
        check("hold single_hs", 64'(flag), 0);

        // Abort during the 4th RUN cycle.
        wait_ready(0, "abort");
        set_in(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        set_in(0, 1'b0, 64'd0);
        repeat (3) @(posedge clk);
        #1 abort64 = 1'b1;
        @(posedge clk); #1;
        abort64 = 1'b0;
        check("abort idle", {62'd0, busy64, bus64.out_valid}, 0);
        #1 check("abort ready", 64'(bus64.in_ready), 1);
        flag = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus64.out_valid) flag = 1'b1;
        end
        check("abort no_result", 64'(flag), 0);
        run_word(0, 64'hFF, 8, 8, "after_abort");

        // Abort together with a valid word in IDLE.
        abort64 = 1'b1;
        set_in(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        #1 check("abort_in ready_low", 64'(bus64.in_ready), 0);
        @(posedge clk); #1;
        abort64 = 1'b0;
        set_in(0, 1'b0, 64'd0);
        check("abort_in not_accepted", 64'(busy64), 0);

        // Asynchronous reset mid-RUN.
        wait_ready(0, "rst");
        set_in(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        set_in(0, 1'b0, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst async", {61'd0, busy64, bus64.out_valid, bus64.in_ready}, 0);
        check("rst count", get_count(0), 0);
        #1 rst_n = 1'b1;
        #1 check("rst ready_low", 64'(bus64.in_ready), 0);
        @(posedge clk); #1;
        check("rst ready_high", 64'(bus64.in_ready), 1);
        run_word(0, 64'hF0F0_F0F0_F0F0_F0F0, 32, 8, "after_rst");

        // WIDTH=8 instance: single RUN cycle.
        run_word(1, 64'hA5, 4, 1, "w8_a5");
        run_word(1, 64'hFF, 8, 1, "w8_ff");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
